// File: rtl/fs_dither_stream.sv
// rtl/fs_dither_stream.sv - streaming grayscale quantizer with Floyd-Steinberg error diffusion
module fs_dither_stream #(
  parameter int IMAGEX   = 64,
  parameter int IMAGEY   = 64,
  parameter int RGB_SIZE = 8,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dither_en,
  input  logic [RGB_SIZE-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_sof,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] out_code,
  output logic [RGB_SIZE-1:0] out_pixel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_eol,
  output logic                out_eof
);

  localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam int EW = RGB_SIZE + 2;   // pixel error
  localparam int AW = RGB_SIZE + 6;   // weighted error accumulators
  localparam int VW = AW + 1;         // pixel plus scaled correction
  localparam logic [XW-1:0] X_LAST = XW'(IMAGEX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGEY - 1);

  // position and frame state
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic                 r_den;
  // error state: west neighbour error, two open next-row partial sums, row buffer
  logic signed [EW-1:0] r_eprev;
  logic signed [AW-1:0] r_p0;
  logic signed [AW-1:0] r_p1;
  logic signed [AW-1:0] r_rowbuf [IMAGEX];
  // output registers
  logic                 r_valid;
  logic [OUT_BITS-1:0]  r_code;
  logic [RGB_SIZE-1:0]  r_pix;
  logic                 r_eol;
  logic                 r_eof;

  logic                 w_accept;
  logic [XW-1:0]        w_x;
  logic [YW-1:0]        w_y;
  logic                 w_den;
  logic                 w_first_col;
  logic                 w_first_row;
  logic                 w_last_col;
  logic                 w_last_row;
  logic signed [AW-1:0] w_eprev_ext;
  logic signed [AW-1:0] w_west;
  logic signed [AW-1:0] w_north;
  logic signed [AW-1:0] w_corr;
  logic signed [AW-1:0] w_shift;
  logic signed [VW-1:0] w_sum;
  logic [RGB_SIZE-1:0]  w_v;
  logic [OUT_BITS-1:0]  w_code;
  logic [RGB_SIZE-1:0]  w_pix;
  logic signed [EW-1:0] w_e;
  logic signed [AW-1:0] w_e_ext;
  logic signed [AW-1:0] w_e3;
  logic signed [AW-1:0] w_e5;
  logic signed [AW-1:0] w_nb_prev;
  logic signed [AW-1:0] w_nb_cur;
  logic signed [AW-1:0] w_nb_prev_wr;
  logic signed [AW-1:0] w_nb_cur_wr;

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_valid;
  assign out_code  = r_code;
  assign out_pixel = r_pix;
  assign out_eol   = r_eol;
  assign out_eof   = r_eof;

  // a start-of-frame beat is pixel (0,0) no matter where the counters are
  assign w_x         = in_sof ? '0 : r_x;
  assign w_y         = in_sof ? '0 : r_y;
  assign w_den       = in_sof ? dither_en : r_den;
  assign w_first_col = (w_x == '0);
  assign w_first_row = (w_y == '0);
  assign w_last_col  = (w_x == X_LAST);
  assign w_last_row  = (w_y == Y_LAST);

  // correction: 7/16 from the west pixel plus the row buffer entry, which already
  // holds 1*NW + 5*N + 3*NE gathered while the previous row streamed past
  assign w_eprev_ext = {{(AW-EW){r_eprev[EW-1]}}, r_eprev};
  assign w_west      = w_first_col ? '0 : ((w_eprev_ext <<< 3) - w_eprev_ext);
  assign w_north     = w_first_row ? '0 : r_rowbuf[w_x];
  assign w_corr      = w_den ? (w_west + w_north) : '0;
  assign w_shift     = w_corr >>> 4;
  assign w_sum       = $signed({{(VW-RGB_SIZE){1'b0}}, in_data}) + $signed({w_shift[AW-1], w_shift});

  // clamp the corrected value into the pixel range
  always_comb begin
    w_v = w_sum[RGB_SIZE-1:0];
    if (w_sum[VW-1]) begin
      w_v = '0;
    end else if (|w_sum[VW-2:RGB_SIZE]) begin
      w_v = '1;
    end
  end

  assign w_code = w_v[RGB_SIZE-1 -: OUT_BITS];

  // expand the code back to full width by repeating its bits from the MSB down
  for (genvar gi = 0; gi < RGB_SIZE; gi++) begin : g_rep
    assign w_pix[gi] = w_code[OUT_BITS-1-((RGB_SIZE-1-gi) % OUT_BITS)];
  end

  assign w_e     = $signed({2'b00, w_v}) - $signed({2'b00, w_pix});
  assign w_e_ext = {{(AW-EW){w_e[EW-1]}}, w_e};
  assign w_e3    = (w_e_ext <<< 1) + w_e_ext;
  assign w_e5    = (w_e_ext <<< 2) + w_e_ext;

  // column x-1 of the next row is complete once this pixel adds its 3/16;
  // column x gets 5/16 now and waits for the east pixel's 3/16
  assign w_nb_prev    = r_p0 + w_e3;
  assign w_nb_cur     = (w_first_col ? '0 : r_p1) + w_e5;
  // nothing diffuses below the last row, which also leaves the buffer clean for the next frame
  assign w_nb_prev_wr = w_last_row ? '0 : w_nb_prev;
  assign w_nb_cur_wr  = w_last_row ? '0 : w_nb_cur;

  // output beat register: load on accept, drop when consumed, hold under back-pressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_pix   <= '0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_code  <= w_code;
      r_pix   <= w_pix;
      r_eol   <= w_last_col;
      r_eof   <= w_last_col && w_last_row;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // raster position, frame dither enable and diffused error state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_den   <= 1'b0;
      r_eprev <= '0;
      r_p0    <= '0;
      r_p1    <= '0;
      for (int i = 0; i < IMAGEX; i++) begin
        r_rowbuf[i] <= '0;
      end
    end else if (w_accept) begin
      r_den   <= w_den;
      r_eprev <= w_e;
      r_p0    <= w_nb_cur;
      r_p1    <= w_e_ext;
      if (in_sof) begin
        for (int i = 0; i < IMAGEX; i++) begin
          r_rowbuf[i] <= '0;
        end
      end
      if (!w_first_col) begin
        r_rowbuf[w_x - 1'b1] <= w_nb_prev_wr;
      end
      if (w_last_col) begin
        r_rowbuf[w_x] <= w_nb_cur_wr;
        r_x           <= '0;
        if (w_last_row) begin
          r_y   <= '0;
          r_den <= dither_en;
        end else begin
          r_y <= w_y + 1'b1;
        end
      end else begin
        r_x <= w_x + 1'b1;
        r_y <= w_y;
      end
    end
  end

endmodule

// File: tb/tb_fs_dither_stream.sv
// tb/tb_fs_dither_stream.sv - directed self-checking bench for fs_dither_stream
module tb_fs_dither_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       dither_en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic       out_code;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_ready;
  logic       out_eol;
  logic       out_eof;

  logic       b_dither_en;
  logic [7:0] b_in_data;
  logic       b_in_valid;
  logic       b_in_sof;
  logic       b_in_ready;
  logic [1:0] b_out_code;
  logic [7:0] b_out_pixel;
  logic       b_out_valid;
  logic       b_out_eol;
  logic       b_out_eof;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       code;
    logic [7:0] pix;
    logic       eol;
    logic       eof;
  } beat_t;

  beat_t q[$];
  beat_t mon_b;

  always #5 clk = ~clk;

  fs_dither_stream #(.IMAGEX(4), .IMAGEY(2), .RGB_SIZE(8), .OUT_BITS(1)) dut (
    .clk(clk), .rst(rst), .dither_en(dither_en), .in_data(in_data),
    .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .out_code(out_code), .out_pixel(out_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .out_eol(out_eol), .out_eof(out_eof)
  );

  fs_dither_stream #(.IMAGEX(4), .IMAGEY(2), .RGB_SIZE(8), .OUT_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .dither_en(b_dither_en), .in_data(b_in_data),
    .in_valid(b_in_valid), .in_sof(b_in_sof), .in_ready(b_in_ready),
    .out_code(b_out_code), .out_pixel(b_out_pixel), .out_valid(b_out_valid),
    .out_ready(1'b1), .out_eol(b_out_eol), .out_eof(b_out_eof)
  );

  // record every completed output handshake of the main instance
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_b.code = out_code;
      mon_b.pix  = out_pixel;
      mon_b.eol  = out_eol;
      mon_b.eof  = out_eof;
      q.push_back(mon_b);
    end
  end

  task automatic drive(input logic [7:0] d, input logic sof);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    checks++; if (out_code !== 1'b0) begin failures++; $display("FAIL rst_code: got %0b want 0", out_code); end
    checks++; if (out_pixel !== 8'd0) begin failures++; $display("FAIL rst_pixel: got %0d want 0", out_pixel); end
    checks++; if (out_eol !== 1'b0) begin failures++; $display("FAIL rst_eol: got %0b want 0", out_eol); end
    checks++; if (out_eof !== 1'b0) begin failures++; $display("FAIL rst_eof: got %0b want 0", out_eof); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_threshold();
    logic [7:0] din [4]  = '{8'd127, 8'd128, 8'd0, 8'd255};
    logic       ec  [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    dither_en = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) drive(din[i], (i == 0));
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 4) begin
      failures++; $display("FAIL thr_count: got %0d want 4", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (q[i].code !== ec[i]) begin failures++; $display("FAIL thr_code[%0d]: got %0b want %0b", i, q[i].code, ec[i]); end
        checks++; if (q[i].pix !== (ec[i] ? 8'd255 : 8'd0)) begin failures++; $display("FAIL thr_pixel[%0d]: got %0d want %0d", i, q[i].pix, ec[i] ? 255 : 0); end
        checks++; if (q[i].eol !== (i == 3)) begin failures++; $display("FAIL thr_eol[%0d]: got %0b want %0b", i, q[i].eol, (i == 3)); end
        checks++; if (q[i].eof !== 1'b0) begin failures++; $display("FAIL thr_eof[%0d]: got %0b want 0", i, q[i].eof); end
      end
    end
  endtask

  task automatic test_diffusion();
    logic ec [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    dither_en = 1'b1;
    q.delete();
    for (int i = 0; i < 8; i++) drive(8'd128, (i == 0));
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 8) begin
      failures++; $display("FAIL dif_count: got %0d want 8", q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (q[i].code !== ec[i]) begin failures++; $display("FAIL dif_code[%0d]: got %0b want %0b", i, q[i].code, ec[i]); end
        checks++; if (q[i].pix !== (ec[i] ? 8'd255 : 8'd0)) begin failures++; $display("FAIL dif_pixel[%0d]: got %0d want %0d", i, q[i].pix, ec[i] ? 255 : 0); end
        checks++; if (q[i].eol !== (i == 3 || i == 7)) begin failures++; $display("FAIL dif_eol[%0d]: got %0b", i, q[i].eol); end
        checks++; if (q[i].eof !== (i == 7)) begin failures++; $display("FAIL dif_eof[%0d]: got %0b want %0b", i, q[i].eof, (i == 7)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ec [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    dither_en = 1'b1;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd128;
        in_sof    = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
          checks++; if (out_valid !== 1'b1 || out_code !== 1'b1 || out_pixel !== 8'd255 || out_eol !== 1'b0) begin
            failures++; $display("FAIL bp_hold: got v=%0b c=%0b p=%0d eol=%0b want v=1 c=1 p=255 eol=0", out_valid, out_code, out_pixel, out_eol);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      drive(8'd128, (i == 0));
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 8) begin
      failures++; $display("FAIL bp_count: got %0d want 8", q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (q[i].code !== ec[i] || q[i].eof !== (i == 7)) begin
          failures++; $display("FAIL bp_beat[%0d]: got c=%0b eof=%0b want c=%0b eof=%0b", i, q[i].code, q[i].eof, ec[i], (i == 7));
        end
      end
    end
  endtask

  task automatic test_resync();
    dither_en = 1'b1;
    q.delete();
    drive(8'd128, 1'b1);
    drive(8'd128, 1'b0);
    drive(8'd100, 1'b1);
    for (int i = 0; i < 7; i++) drive(8'd128, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 10) begin
      failures++; $display("FAIL rs_count: got %0d want 10", q.size());
    end else begin
      checks++; if (q[2].code !== 1'b0 || q[2].pix !== 8'd0) begin failures++; $display("FAIL rs_sof_beat: got c=%0b p=%0d want c=0 p=0", q[2].code, q[2].pix); end
      checks++; if (q[3].code !== 1'b1) begin failures++; $display("FAIL rs_next_beat: got %0b want 1", q[3].code); end
      for (int i = 0; i < 10; i++) begin
        checks++; if (q[i].eol !== (i == 5 || i == 9)) begin failures++; $display("FAIL rs_eol[%0d]: got %0b want %0b", i, q[i].eol, (i == 5 || i == 9)); end
        checks++; if (q[i].eof !== (i == 9)) begin failures++; $display("FAIL rs_eof[%0d]: got %0b want %0b", i, q[i].eof, (i == 9)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    dither_en = 1'b1;
    drive(8'd128, 1'b1);
    drive(8'd128, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd128;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid: got %0b want 0", out_valid); end
    checks++; if (out_pixel !== 8'd0) begin failures++; $display("FAIL rm_pixel: got %0d want 0", out_pixel); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready: got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
    q.delete();
    for (int i = 0; i < 8; i++) drive(8'd128, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 8) begin
      failures++; $display("FAIL rm_count: got %0d want 8", q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (q[i].code !== 1'b1 || q[i].pix !== 8'd255) begin failures++; $display("FAIL rm_beat[%0d]: got c=%0b p=%0d want c=1 p=255", i, q[i].code, q[i].pix); end
        checks++; if (q[i].eol !== (i == 3 || i == 7) || q[i].eof !== (i == 7)) begin
          failures++; $display("FAIL rm_flags[%0d]: got eol=%0b eof=%0b", i, q[i].eol, q[i].eof);
        end
      end
    end
  endtask

  task automatic test_saturation();
    b_dither_en = 1'b1;
    b_in_valid  = 1'b1;
    b_in_sof    = 1'b1;
    b_in_data   = 8'd250;
    @(posedge clk);
    #1;
    b_in_sof = 1'b0;
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b1 || b_out_code !== 2'd3 || b_out_pixel !== 8'd255) begin
      failures++; $display("FAIL sat_beat0: got v=%0b c=%0d p=%0d want v=1 c=3 p=255", b_out_valid, b_out_code, b_out_pixel);
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b1 || b_out_code !== 2'd3 || b_out_pixel !== 8'd255) begin
      failures++; $display("FAIL sat_beat1: got v=%0b c=%0d p=%0d want v=1 c=3 p=255", b_out_valid, b_out_code, b_out_pixel);
    end
    @(posedge clk);
    #1;
    b_dither_en = 1'b0;
    b_in_valid  = 1'b1;
    b_in_sof    = 1'b1;
    b_in_data   = 8'd100;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in_sof   = 1'b0;
    @(negedge clk);
    checks++; if (b_out_code !== 2'd1 || b_out_pixel !== 8'd85 || b_out_eol !== 1'b0 || b_out_eof !== 1'b0) begin
      failures++; $display("FAIL rep_code1: got c=%0d p=%0d eol=%0b eof=%0b want c=1 p=85 eol=0 eof=0", b_out_code, b_out_pixel, b_out_eol, b_out_eof);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    dither_en   = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    in_sof      = 1'b0;
    out_ready   = 1'b1;
    b_dither_en = 1'b0;
    b_in_data   = '0;
    b_in_valid  = 1'b0;
    b_in_sof    = 1'b0;
    test_reset();
    test_threshold();
    test_diffusion();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fs_dither_stream.md
FS_DITHER_STREAM -- requirements
Module: fs_dither_stream

Interface
REQ-001 SHALL have parameter IMAGEX, default 64, meaning pixels per row (>=2).
REQ-002 SHALL have parameter IMAGEY, default 64, meaning rows per frame (>=1).
REQ-003 SHALL have parameter RGB_SIZE, default 8, meaning input/output pixel width.
REQ-004 SHALL have parameter OUT_BITS, default 1, meaning quantized code width (1..RGB_SIZE-1).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port dither_en  input  1  1 = Floyd-Steinberg error diffusion, 0 = plain quantization.
REQ-008 SHALL have port in_data  input  RGB_SIZE  unsigned grayscale pixel, raster order.
REQ-009 SHALL have port in_valid  input  1  in_data valid.
REQ-010 SHALL have port in_sof  input  1  qualifies the beat as pixel (0,0) of a new frame.
REQ-011 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-012 SHALL have port out_code  output  OUT_BITS  quantized level code.
REQ-013 SHALL have port out_pixel  output  RGB_SIZE  code expanded to RGB_SIZE by bit replication.
REQ-014 SHALL have port out_valid  output  1  out_* valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts.
REQ-016 SHALL have port out_eol  output  1  beat is last pixel of a row.
REQ-017 SHALL have port out_eof  output  1  beat is last pixel of the frame.

Function
REQ-018 SHALL accept a beat when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-019 SHALL register the result of an accepted beat onto out_* on the next clock (latency 1); out_* SHALL hold stable while out_valid && !out_ready.
REQ-020 SHALL sustain one pixel per cycle with out_ready held high.
REQ-021 SHALL track column x (0..IMAGEX-1) and row y (0..IMAGEY-1), advancing per accepted beat; x wraps to 0 and y increments at x=IMAGEX-1; both wrap to 0 after (IMAGEX-1, IMAGEY-1).
REQ-022 SHALL, on an accepted beat with in_sof=1, treat it as (0,0) regardless of counters, clear all stored error, and latch dither_en for the frame; dither_en SHALL also be latched whenever counters wrap to (0,0).
REQ-023 SHALL compute corrected value v = in_data + (corr >>> 4), where >>> is arithmetic shift (floor), saturated to [0, 2^RGB_SIZE-1]; corr = 0 when latched dither_en=0.
REQ-024 SHALL compute out_code = v >> (RGB_SIZE-OUT_BITS), out_pixel = bit-replicated out_code, error e = v - out_pixel (signed, RGB_SIZE+2 bits).
REQ-025 SHALL form corr(x,y) = 7*e(x-1,y) + 1*e(x-1,y-1) + 5*e(x,y-1) + 3*e(x+1,y-1), each term present only if that neighbour exists in the current frame; accumulators SHALL be signed RGB_SIZE+6 bits, no overflow.
REQ-026 SHALL hold next-row partial sums in an IMAGEX-entry row buffer; no SRAM read-modify-write of pixel data.
REQ-027 SHALL discard contributions east of x=IMAGEX-1, west of x=0, and below y=IMAGEY-1.
REQ-028 SHALL assert out_eol when the output beat has x=IMAGEX-1 and out_eof when also y=IMAGEY-1.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set out_valid=0, out_code=0, out_pixel=0, out_eol=0, out_eof=0, x=y=0, clear all error state and latch dither_en=0; rst SHALL override an in-flight handshake and mid-frame state.
REQ-030 SHALL drive in_ready=1 during the first cycle after reset deasserts.

Verification (IMAGEX=4, IMAGEY=2, RGB_SIZE=8, OUT_BITS=1 unless stated)
REQ-031 Reset: assert rst 2 cycles mid-stream -> out_valid=0, out_pixel=0, next beat processed as (0,0) with zero correction.
REQ-032 Threshold: dither_en=0, stream 127,128,0,255 -> out_code 0,1,0,1; out_pixel 0,255,0,255; out_eol on 4th beat.
REQ-033 Diffusion: dither_en=1, in_sof on first beat, all 8 pixels =128 -> beat0 out_pixel 255 (e=-127); beat1 corr=-889 -> v=72 -> out_pixel 0; out_eof only on beat 7.
REQ-034 Back-pressure: out_ready low 3 cycles with in_valid high -> in_ready low, out_* unchanged, no beat lost or duplicated; resumed stream matches REQ-033 values.
REQ-035 Resync: in_sof asserted on 3rd beat of a dithered frame, in_data=100 -> out_code 0, out_eol/out_eof counted from that beat.
REQ-036 Saturation: OUT_BITS=2, dither_en=1, row 0 = 250,250 -> beat0 code 3/255 (e=-5), beat1 corr=-35 -> v=247 -> code 3, out_pixel 255.
